// File: rtl/fp64_mantissa_div_iter_if.sv
// Handshake bundle for the FP64 significand divider: operand side and result side.
// The producer/consumer uses the master modport; the divider uses the slave modport.
interface fp64_mantissa_div_iter_if #(parameter int QW = 55);
  logic          in_valid;
  logic          in_ready;
  logic [52:0]   mant_a;
  logic [52:0]   mant_b;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quot;
  logic          sticky;
  logic          dz;
  logic          range_err;
  logic          busy;

  modport master (
    output in_valid, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, quot, sticky, dz, range_err, busy
  );

  modport slave (
    input  in_valid, mant_a, mant_b, out_ready,
    output in_ready, out_valid, quot, sticky, dz, range_err, busy
  );
endinterface

// File: rtl/fp64_mantissa_div_iter.sv
// Iterative radix-2 restoring divider for FP64 significands: one quotient bit per cycle,
// 55-bit truncated quotient plus sticky for the downstream normalize/round stage.
module fp64_mantissa_div_iter #(
  parameter int QW = 55
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fp64_mantissa_div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [QW-1:0] r_rem;
  logic [52:0]   r_div;
  logic [5:0]    r_cnt;
  logic [QW-1:0] r_quot;
  logic          r_sticky;
  logic          r_dz;
  logic          r_range_err;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          r_busy;

  logic [QW-1:0] w_div_ext;
  logic [QW-1:0] w_diff;
  logic [QW-1:0] w_rem_next;
  logic          w_ge;
  logic          w_last_sticky;
  logic          w_accept;
  logic          w_range;

  // Datapath for one restoring step plus the accept-time range check
  always_comb begin
    w_div_ext     = {2'b00, r_div};
    w_ge          = (r_rem >= w_div_ext);
    w_diff        = r_rem - w_div_ext;
    w_accept      = bus.in_valid & r_in_ready;
    // a < 2b keeps every partial remainder below 2*div, so 55 bits suffice
    w_range       = ({1'b0, bus.mant_a} >= {bus.mant_b, 1'b0});
    if (w_ge) begin
      w_rem_next    = {w_diff[QW-2:0], 1'b0};
      w_last_sticky = (w_diff != {QW{1'b0}});
    end else begin
      w_rem_next    = {r_rem[QW-2:0], 1'b0};
      w_last_sticky = (r_rem != {QW{1'b0}});
    end
  end

  // Control FSM with all outputs held in registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rem       <= {QW{1'b0}};
      r_div       <= 53'd0;
      r_cnt       <= 6'd0;
      r_quot      <= {QW{1'b0}};
      r_sticky    <= 1'b0;
      r_dz        <= 1'b0;
      r_range_err <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_range) begin
              r_quot      <= {QW{1'b1}};
              r_sticky    <= 1'b1;
              r_range_err <= 1'b1;
              r_dz        <= (bus.mant_b == 53'd0);
              r_state     <= S_DONE;
            end else begin
              r_rem       <= {2'b00, bus.mant_a};
              r_div       <= bus.mant_b;
              r_cnt       <= 6'd54;
              r_quot      <= {QW{1'b0}};
              r_sticky    <= 1'b0;
              r_range_err <= 1'b0;
              r_dz        <= 1'b0;
              r_state     <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_quot[r_cnt] <= w_ge;
          r_rem         <= w_rem_next;
          if (r_cnt == 6'd0) begin
            r_sticky    <= w_last_sticky;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DONE: begin
          // Early-exit results enter DONE with out_valid still low; raise it one edge later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quot      = r_quot;
  assign bus.sticky    = r_sticky;
  assign bus.dz        = r_dz;
  assign bus.range_err = r_range_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_fp64_mantissa_div_iter.sv
// Scoreboard bench for the iterative significand divider: directed, boundary,
// backpressure, reset-abort and random divides against an exact reference quotient.
module tb_fp64_mantissa_div_iter;

  typedef struct packed {
    logic [54:0] q;
    logic        s;
    logic        dz;
    logic        re;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  fp64_mantissa_div_iter_if #(.QW(55)) bus ();

  fp64_mantissa_div_iter #(.QW(55)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [52:0] rand53();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[52:0];
  endfunction

  // Exact reference: floor(a * 2^54 / b) with the range/zero-divisor early exit
  function automatic exp_t ref_div(input logic [52:0] a, input logic [52:0] b);
    exp_t         e;
    logic [106:0] num;
    logic [106:0] den;
    logic [106:0] q;
    logic [106:0] r;
    if ({1'b0, a} >= {b, 1'b0}) begin
      e.q  = {55{1'b1}};
      e.s  = 1'b1;
      e.dz = (b == 53'd0);
      e.re = 1'b1;
    end else begin
      num  = {a, 54'd0};
      den  = {54'd0, b};
      q    = num / den;
      r    = num % den;
      e.q  = q[54:0];
      e.s  = (r != 107'd0);
      e.dz = 1'b0;
      e.re = 1'b0;
    end
    return e;
  endfunction

  task automatic send(input logic [52:0] a, input logic [52:0] b, input exp_t e);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check_eq("in_ready_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b1;
    bus.mant_a   = a;
    bus.mant_b   = b;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mant_a   = rand53();
    bus.mant_b   = rand53();
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, "_quot"},  64'(bus.quot),      64'(e.q));
    check_eq({tag, "_stky"},  64'(bus.sticky),    64'(e.s));
    check_eq({tag, "_dz"},    64'(bus.dz),        64'(e.dz));
    check_eq({tag, "_rerr"},  64'(bus.range_err), 64'(e.re));
    check_eq({tag, "_vld"},   64'(bus.out_valid), 64'd1);
    check_eq({tag, "_rdy"},   64'(bus.in_ready),  64'd0);
    check_eq({tag, "_busy"},  64'(bus.busy),      64'd1);
  endtask

  // Called on the negedge right after the accept edge; waits, stalls, then consumes
  task automatic recv(input string tag, input int exp_lat, input int stall);
    int   lat;
    exp_t e;
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_underflow"}, 64'd0, 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = (i >= 2 && i < 6);
      bus.mant_a   = 53'h10000000000000;
      bus.mant_b   = rand53() | 53'h10000000000000;
      @(negedge clk);
      check_outputs({tag, "_hold"}, e);
    end
    bus.in_valid = 1'b0;
    check_outputs(tag, e);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, "_post_vld"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_post_rdy"}, 64'(bus.in_ready),  64'd1);
  endtask

  task automatic run_op(input string tag, input logic [52:0] a, input logic [52:0] b,
                        input exp_t e, input int exp_lat, input int stall);
    send(a, b, e);
    recv(tag, exp_lat, stall);
  endtask

  initial begin
    logic [52:0] a;
    logic [52:0] b;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mant_a    = 53'd0;
    bus.mant_b    = 53'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_quot",      64'(bus.quot),      64'd0);
    check_eq("rst_sticky",    64'(bus.sticky),    64'd0);
    check_eq("rst_dz",        64'(bus.dz),        64'd0);
    check_eq("rst_range",     64'(bus.range_err), 64'd0);
    check_eq("rst_busy",      64'(bus.busy),      64'd0);
    rst = 1'b0;

    run_op("one_one", 53'h10000000000000, 53'h10000000000000,
           '{q: 55'h40000000000000, s: 1'b0, dz: 1'b0, re: 1'b0}, 55, 0);
    run_op("1p5_one", 53'h18000000000000, 53'h10000000000000,
           '{q: 55'h60000000000000, s: 1'b0, dz: 1'b0, re: 1'b0}, 55, 0);
    run_op("one_1p5", 53'h10000000000000, 53'h18000000000000,
           '{q: 55'h2AAAAAAAAAAAAA, s: 1'b1, dz: 1'b0, re: 1'b0}, 55, 0);
    run_op("div_zero", 53'h1234567890ABCD, 53'd0,
           '{q: 55'h7FFFFFFFFFFFFF, s: 1'b1, dz: 1'b1, re: 1'b1}, 1, 0);
    run_op("range", 53'h1FFFFFFFFFFFFF, 53'h08000000000000,
           '{q: 55'h7FFFFFFFFFFFFF, s: 1'b1, dz: 1'b0, re: 1'b1}, 1, 0);
    run_op("range_edge", 53'h1FFFFFFFFFFFFE, 53'h0FFFFFFFFFFFFF,
           '{q: 55'h7FFFFFFFFFFFFF, s: 1'b1, dz: 1'b0, re: 1'b1}, 1, 0);
    run_op("below_range", 53'h1FFFFFFFFFFFFF, 53'h10000000000000,
           '{q: 55'h7FFFFFFFFFFFFC, s: 1'b0, dz: 1'b0, re: 1'b0}, 55, 0);

    for (int i = 0; i < 6; i++) begin
      a = rand53() | 53'h10000000000000;
      b = rand53() | 53'h10000000000000;
      run_op("rand", a, b, ref_div(a, b), 55, 0);
    end

    run_op("backpr", 53'h10000000000000, 53'h18000000000000,
           '{q: 55'h2AAAAAAAAAAAAA, s: 1'b1, dz: 1'b0, re: 1'b0}, 55, 10);
    a = rand53() | 53'h10000000000000;
    b = rand53() | 53'h10000000000000;
    run_op("after_bp", a, b, ref_div(a, b), 55, 0);

    // Abort mid-calculation, with a competing in_valid on the reset edge
    send(53'h1ABCDEF0123456, 53'h11111111111111, ref_div(53'h1ABCDEF0123456, 53'h11111111111111));
    void'(sb.pop_back());
    repeat (19) @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.mant_a   = 53'h10000000000000;
    bus.mant_b   = 53'h10000000000000;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy",  64'(bus.busy),      64'd0);
    check_eq("abort_vld",   64'(bus.out_valid), 64'd0);
    check_eq("abort_quot",  64'(bus.quot),      64'd0);
    check_eq("abort_rdy",   64'(bus.in_ready),  64'd1);
    check_eq("abort_stky",  64'(bus.sticky),    64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_noacc_rdy",  64'(bus.in_ready), 64'd1);
    check_eq("abort_noacc_busy", 64'(bus.busy),     64'd0);
    run_op("post_rst", 53'h18000000000000, 53'h10000000000000,
           '{q: 55'h60000000000000, s: 1'b0, dz: 1'b0, re: 1'b0}, 55, 0);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp64_mantissa_div_iter.md
# fp64_mantissa_div_iter

Iterative radix-2 restoring divider for FP64 significands: the division counterpart of the pipelined mantissa multiplier in the FP64 datapath. It takes two 53-bit significands with the hidden bit included and returns a 55-bit truncated quotient plus a sticky bit for the downstream normalize/round stage. The block processes one operation at a time, with ready/valid handshakes on both the input and output sides.

## Interface
- `QW`, default 55: quotient width. Fixed at 55; no other value is supported.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an operand pair is offered.
- `in_ready`  out  1  the block accepts an operand pair this cycle. Reset value 1.
- `mant_a`  in  53  dividend significand.
- `mant_b`  in  53  divisor significand.
- `out_valid`  out  1  the result is held stable on the outputs. Reset value 0.
- `out_ready`  in  1  the consumer takes the result this cycle.
- `quot`  out  55  quotient, equal to floor(`mant_a` × 2^54 / `mant_b`). Reset value 0.
- `sticky`  out  1  set when the final remainder is nonzero. Reset value 0.
- `dz`  out  1  divide by zero: `mant_b` was 0. Reset value 0.
- `range_err`  out  1  the quotient would not fit: `mant_a` ≥ 2·`mant_b`. Reset value 0.
- `busy`  out  1  the state is CALC or DONE. Reset value 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- `in_ready` equals (state == IDLE).
- Accept occurs when `in_valid` and `in_ready` are both high.
  - Check: {1'b0,`mant_a`} ≥ {`mant_b`,1'b0}.
  - If the check is true: `quot` = all ones, `sticky` = 1, `range_err` = 1, `dz` = (`mant_b`==0), then go to DONE.
  - Otherwise: load `rem` (55 bits) = `mant_a`, `div` = `mant_b`, `cnt` = 54, clear all flags, go to CALC.
- Each CALC cycle produces one quotient bit:
  - If `rem` ≥ `div`: set `quot`[`cnt`] = 1 and `rem` = (`rem` − `div`) << 1.
  - Otherwise: set `quot`[`cnt`] = 0 and `rem` = `rem` << 1.
  - Quotient bits are produced MSB first. Each unused bit is 0, written before it is used.
- When `cnt` == 0, the bit is written, then:
  - `sticky` = (remainder after subtraction != 0), evaluated before the shift.
  - Go to DONE.
  - Otherwise decrement `cnt`.
- Width rules:
  - `rem` < 2·`div` at all times, so 55 bits never overflow.
  - The subtraction is a 55-bit unsigned operation.
- In DONE:
  - `out_valid` = 1.
  - `quot`, `sticky`, `dz` and `range_err` hold stable until the transfer (`out_valid` and `out_ready` both high).
  - On transfer, go to IDLE. `out_valid` drops on the next cycle.
- There is no same-cycle handoff. The next accept is possible at the earliest one cycle after the transfer.
- `in_valid` while the block is not ready is ignored. The operands are not latched.
- Operand inputs are sampled only on the accept edge. They may change freely afterwards.
- Reset is synchronous:
  - It aborts any operation in any state.
  - All outputs return to their reset values on the edge where `rst` is high. `in_ready` returns to 1 on that same edge.
- Results are truncated. Rounding belongs to the downstream stage, which uses `quot`[1:0] and `sticky`.

## Timing
- Normal divide:
  - Accept at edge T0.
  - The 55 CALC edges are T1..T55.
  - `out_valid` goes high after T55, i.e. 55 cycles after acceptance.
- `range_err`/`dz` path: `out_valid` goes high after T1.
- Throughput: at most one operation per 57 cycles when `out_ready` is tied high.
- Transfer edge and IDLE: `out_valid` = 0 and `in_ready` = 1 in the cycle after the transfer edge.
- Backpressure: DONE is held indefinitely. The outputs must not change, and `in_ready` stays 0.
- `rst` asserted in the same cycle as `in_valid`: reset wins and nothing is accepted.

## Test plan
- `mant_a` = `mant_b` = 2^52 → after 55 cycles, `quot` = 2^54, `sticky` = 0, `dz` = 0, `range_err` = 0.
- `mant_a` = 3·2^51, `mant_b` = 2^52 (1.5/1.0) → `quot` = 3·2^53, `sticky` = 0.
- `mant_a` = 2^52, `mant_b` = 3·2^51 → `quot` = 55'h2AAAAAAAAAAAAA, `sticky` = 1.
- `mant_b` = 0, any `mant_a` → `out_valid` one cycle after acceptance, `quot` = 55'h7FFFFFFFFFFFFF, `sticky` = 1, `dz` = 1, `range_err` = 1.
- A valid result with `out_ready` held at 0 for 10 cycles, and `in_valid` pulsed with new operands during that time:
  - `out_valid` stays at 1 and all outputs remain unchanged.
  - `in_ready` = 0 and the new operands are not accepted.
  - After `out_ready` goes high, the next operation is accepted and matches its reference result.
- `rst` pulsed at CALC cycle 20:
  - On the next edge: `busy` = 0, `out_valid` = 0, `quot` = 0, `in_ready` = 1.
  - A subsequent divide of 3·2^51 / 2^52 gives a correct result with no leftover state.
